systolic_ctrl: RTL

Sequencing controller for the N×N floating-point systolic array built from `pe` cells. On a start command it clears the array accumulators. It then streams the inner dimension K from per-lane operand buffers into the array edges, skewing row i by i cycles and column j by j cycles. It then waits for the wavefront to drain and signals done. It sits between the host-side job interface and the array plus its operand buffers, and holds no datapath arithmetic itself.

---
 rtl/systolic_pkg.sv | 11 +
 rtl/systolic_ctrl_if.sv | 9 +
 rtl/skew_lane_gen.sv | 28 ++
 rtl/systolic_ctrl.sv | 87 ++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding, sizing helpers and FP constants for systolic_ctrl
package systolic_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  function automatic int cnt_w(input int n, input int k_max);
    return $clog2(k_max + n);
  endfunction
  function automatic int drain_len(input int n);
    return n + 1;
  endfunction
endpackage

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: host job handshake; master drives start/k_len, slave returns busy/done
interface systolic_ctrl_if #(parameter int KW = 5);
  logic start;
  logic [KW-1:0] k_len;
  logic busy;
  logic done;
  modport master (output start, k_len, input busy, done);
  modport slave (input start, k_len, output busy, done);
endinterface

// File: rtl/skew_lane_gen.sv
// skew_lane_gen: one operand lane; en/addr are a pure function of (t, lane, kc), zero is ~en delayed a cycle
// Ports: clk, rst_n (sync, active-low), act (FEED), t, lane, kc -> en, addr, zero
module skew_lane_gen #(
  parameter int CW = 5,
  parameter int KW = 5,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          act,
  input  logic [CW-1:0] t,
  input  logic [CW-1:0] lane,
  input  logic [KW-1:0] kc,
  output logic          en,
  output logic [AW-1:0] addr,
  output logic          zero
);
  localparam int MW = CW > KW ? CW : KW;
  logic [CW-1:0] d;
  always_comb begin
    d = t >= lane ? t - lane : '0;
    en = act && t >= lane && MW'(d) < MW'(kc);
    addr = en ? d[AW-1:0] : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) zero <= 1'b1;
    else zero <= ~en;
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: IDLE->CLEAR->FEED->DRAIN->DONE sequencer feeding a skewed NxN systolic array
// Ports: clk, rst_n (sync, active-low), job (start/k_len in, busy/done out), acc_clr,
//   a_en/a_addr/a_zero and b_en/b_addr/b_zero per lane; SYSTOLIC_CTRL_PERF_EN adds perf_cycles, perf_jobs
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = 4,
  parameter int K_MAX = 16,
  parameter int AW = $clog2(K_MAX),
  parameter int KW = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  systolic_ctrl_if.slave    job,
  output logic              acc_clr,
  output logic [N-1:0]      a_en,
  output logic [N*AW-1:0]   a_addr,
  output logic [N-1:0]      b_en,
  output logic [N*AW-1:0]   b_addr,
  output logic [N-1:0]      a_zero,
  output logic [N-1:0]      b_zero
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_jobs
`endif
);
  localparam int CW = cnt_w(N, K_MAX);
  localparam int DL = drain_len(N);
  state_t state, state_nxt;
  logic [CW-1:0] t;
  logic [KW-1:0] kc;
  logic feed, feed_last, drain_last;
  assign feed = state == FEED;
  // Last feed step is t = Kc+N-2; drain counts 0..N.
  assign feed_last = t == CW'(kc) + CW'(N - 2);
  assign drain_last = t == CW'(DL - 1);
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = job.start ? CLEAR : IDLE;
      CLEAR:   state_nxt = kc == '0 ? DRAIN : FEED;
      FEED:    state_nxt = feed_last ? DRAIN : FEED;
      DRAIN:   state_nxt = drain_last ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
    job.busy = state != IDLE;
    job.done = state == DONE;
    acc_clr = state == CLEAR;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      t <= '0;
      kc <= '0;
    end else begin
      state <= state_nxt;
      // Only FEED and DRAIN dwell; every state change restarts the step counter.
      t <= state_nxt == state && state != IDLE ? t + CW'(1) : '0;
      if (state == IDLE && job.start) kc <= job.k_len > KW'(K_MAX) ? KW'(K_MAX) : job.k_len;
    end
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane_gen #(.CW(CW), .KW(KW), .AW(AW)) u_a (
      .clk(clk), .rst_n(rst_n), .act(feed), .t(t), .lane(CW'(i)), .kc(kc),
      .en(a_en[i]), .addr(a_addr[i*AW +: AW]), .zero(a_zero[i])
    );
    skew_lane_gen #(.CW(CW), .KW(KW), .AW(AW)) u_b (
      .clk(clk), .rst_n(rst_n), .act(feed), .t(t), .lane(CW'(i)), .kc(kc),
      .en(b_en[i]), .addr(b_addr[i*AW +: AW]), .zero(b_zero[i])
    );
  end
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] cyc;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cyc <= '0;
      perf_cycles <= '0;
      perf_jobs <= '0;
    end else begin
      cyc <= state == IDLE ? '0 : cyc + 32'd1;
      if (state == DONE) begin
        perf_cycles <= cyc + 32'd1;
        perf_jobs <= perf_jobs + 16'd1;
      end
    end
`endif
endmodule
